// File: rtl/riscv_npc_pkg.sv
// Shared types and constants for the next-PC controller.
// Optional RISCV_NPC_RVC_EN selects halfword (compressed) alignment.
package riscv_npc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_IDLE = 2'd1,
    ST_PEND = 2'd2
  } npc_state_e;

  typedef enum logic [1:0] {
    PRIO_SEQ  = 2'd0,
    PRIO_BR   = 2'd1,
    PRIO_XRET = 2'd2,
    PRIO_TRAP = 2'd3
  } npc_prio_e;

  localparam logic [63:0] KERNEL_PC_DEFAULT = 64'h0000_0000_8000_0000;

`ifdef RISCV_NPC_RVC_EN
  localparam logic [63:0] ALIGN_MASK = ~64'h1;
`else
  localparam logic [63:0] ALIGN_MASK = ~64'h3;
`endif

  function automatic logic [63:0] align_tgt(input logic [63:0] tgt);
    return tgt & ALIGN_MASK;
  endfunction

  function automatic logic is_misaligned(input logic [63:0] tgt);
    return (tgt & ~ALIGN_MASK) != 64'h0;
  endfunction

endpackage

// File: rtl/riscv_nextpc_hold.sv
// Pending redirect register: holds target and priority while fetch is stalled,
// overwritten only by a redirect of equal or higher priority.
module riscv_nextpc_hold
  import riscv_npc_pkg::*;
#(
  parameter logic [63:0] KERNEL_PC = KERNEL_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture_i,
  input  logic        offer_i,
  input  logic        clear_i,
  input  logic [63:0] new_target_i,
  input  npc_prio_e   new_prio_i,
  output logic [63:0] pend_target_o,
  output npc_prio_e   pend_prio_o,
  output logic        accept_o
);

  logic [63:0] target_q, target_d;
  npc_prio_e   prio_q, prio_d;

  assign accept_o = (new_prio_i != PRIO_SEQ) && (new_prio_i >= prio_q);

  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (latch).
    target_d = target_q;
    prio_d   = prio_q;
    if (clear_i) begin
      prio_d = PRIO_SEQ;
    end else if (capture_i || (offer_i && accept_o)) begin
      target_d = new_target_i;
      prio_d   = new_prio_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses <= so every flop samples pre-edge values together.
    if (!rst_n) begin
      target_q <= KERNEL_PC;
      prio_q   <= PRIO_SEQ;
    end else begin
      target_q <= target_d;
      prio_q   <= prio_d;
    end
  end

  assign pend_target_o = target_q;
  assign pend_prio_o   = prio_q;

endmodule

// File: rtl/riscv_nextpc_ctrl.sv
// Next-PC selection: boot vector, prioritised redirects, stall-time pending.
// Define RISCV_NPC_RVC_EN for compressed-instruction increments and alignment.
module riscv_nextpc_ctrl
  import riscv_npc_pkg::*;
#(
  parameter logic [63:0] KERNEL_PC = KERNEL_PC_DEFAULT
) (
  input  logic        i_riscv_npc_clk,
  input  logic        i_riscv_npc_rst_n,
  input  logic [63:0] i_riscv_npc_pc,
  input  logic        i_riscv_npc_fetch_stall,
  input  logic        i_riscv_npc_rvc,
  input  logic        i_riscv_npc_br_taken,
  input  logic [63:0] i_riscv_npc_br_target,
  input  logic        i_riscv_npc_trap,
  input  logic [63:0] i_riscv_npc_trap_vec,
  input  logic        i_riscv_npc_xret,
  input  logic [63:0] i_riscv_npc_xret_pc,
  output logic [63:0] o_riscv_npc_nextpc,
  output logic        o_riscv_npc_stallpc,
  output logic        o_riscv_npc_flush,
  output logic        o_riscv_npc_misalign
);

  npc_state_e  state_q, state_d;
  logic [63:0] incr, seq_pc, redir_tgt, pend_target;
  npc_prio_e   redir_prio, pend_prio;
  logic        redir_valid, br_misalign, accept;
  logic        capture, offer, clear;

`ifdef RISCV_NPC_RVC_EN
  assign incr = i_riscv_npc_rvc ? 64'd2 : 64'd4;
`else
  logic rvc_unused;
  assign rvc_unused = i_riscv_npc_rvc;
  assign incr       = 64'd4;
`endif

  assign seq_pc = i_riscv_npc_pc + incr;

  // A misaligned branch is dropped entirely rather than treated as a redirect.
  always_comb begin
    redir_prio  = PRIO_SEQ;
    redir_tgt   = seq_pc;
    br_misalign = 1'b0;
    if (i_riscv_npc_trap) begin
      redir_prio = PRIO_TRAP;
      redir_tgt  = align_tgt(i_riscv_npc_trap_vec);
    end else if (i_riscv_npc_xret) begin
      redir_prio = PRIO_XRET;
      redir_tgt  = align_tgt(i_riscv_npc_xret_pc);
    end else if (i_riscv_npc_br_taken) begin
      if (is_misaligned(i_riscv_npc_br_target)) begin
        br_misalign = 1'b1;
      end else begin
        redir_prio = PRIO_BR;
        redir_tgt  = i_riscv_npc_br_target;
      end
    end
  end

  assign redir_valid = (redir_prio != PRIO_SEQ);

  riscv_nextpc_hold #(.KERNEL_PC(KERNEL_PC)) u_hold (
    .clk           (i_riscv_npc_clk),
    .rst_n         (i_riscv_npc_rst_n),
    .capture_i     (capture),
    .offer_i       (offer),
    .clear_i       (clear),
    .new_target_i  (redir_tgt),
    .new_prio_i    (redir_prio),
    .pend_target_o (pend_target),
    .pend_prio_o   (pend_prio),
    .accept_o      (accept)
  );

  always_comb begin
    state_d              = state_q;
    o_riscv_npc_nextpc   = seq_pc;
    o_riscv_npc_stallpc  = 1'b0;
    o_riscv_npc_flush    = 1'b0;
    o_riscv_npc_misalign = 1'b0;
    capture              = 1'b0;
    offer                = 1'b0;
    clear                = 1'b0;
    case (state_q)
      ST_BOOT: begin
        o_riscv_npc_nextpc  = KERNEL_PC;
        o_riscv_npc_stallpc = 1'b1;
        state_d             = ST_IDLE;
      end
      ST_IDLE: begin
        o_riscv_npc_misalign = br_misalign;
        o_riscv_npc_stallpc  = i_riscv_npc_fetch_stall;
        if (redir_valid) begin
          o_riscv_npc_flush  = 1'b1;
          o_riscv_npc_nextpc = redir_tgt;
          if (i_riscv_npc_fetch_stall) begin
            capture = 1'b1;
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        o_riscv_npc_misalign = br_misalign;
        o_riscv_npc_flush    = accept;
        o_riscv_npc_nextpc   = accept ? redir_tgt : pend_target;
        if (i_riscv_npc_fetch_stall) begin
          o_riscv_npc_stallpc = 1'b1;
          offer               = 1'b1;
        end else begin
          clear   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        o_riscv_npc_nextpc  = KERNEL_PC;
        o_riscv_npc_stallpc = 1'b1;
        state_d             = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge i_riscv_npc_clk or negedge i_riscv_npc_rst_n) begin
    if (!i_riscv_npc_rst_n) state_q <= ST_BOOT;
    else                    state_q <= state_d;
  end

endmodule
